// File: rtl/snax_gemm_tile_sequencer.sv
// -----------------------------------------------------------------------------
// snax_gemm_tile_sequencer
//
// Walks the fixed-size GEMM tile engine across a tiled M x N x K matrix
// multiply. A single job (three base addresses plus three tile counts) is
// accepted from the CSR front-end. The sequencer then issues one command per
// tile, in loop order m (outer), n (middle), k (inner), and waits for the
// engine's per-tile done pulse. After the last tile it raises a one-cycle
// job-done pulse.
//
// Handshakes:
//   cfg  : a job is accepted on any cycle where cfg_valid_i && cfg_ready_o.
//          cfg_ready_o is high only in IDLE; nothing is queued while busy.
//   gemm : a tile command transfers on any cycle where gemm_start_o &&
//          gemm_ready_i. While gemm_start_o is high and gemm_ready_i is low,
//          the addresses and the accumulate flag hold steady.
//          gemm_done_i is a one-cycle pulse that is only observed while
//          waiting for a tile that has already been handed over.
//
// Tile addresses (modulo 2^AddrWidth; wrap-around is silent):
//   A = base_a + (m*K + k) * TileBytesA
//   B = base_b + (n*K + k) * TileBytesB
//   C = base_c + (m*N + n) * TileBytesC
// These are produced by incremental pointer registers, so the address path
// contains adders only and no multipliers.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cfg_valid_i/cfg_ready_o  job handshake
//   cfg_base_{a,b,c}_i       operand base addresses
//   cfg_{m,n,k}_i            tile counts (a count of zero ends the job at once)
//   abort_i                  synchronous abort; no effect in IDLE
//   gemm_start_o/ready_i     tile command handshake
//   gemm_addr_{a,b,c}_o      tile addresses
//   gemm_accumulate_o        add into existing C (k != 0)
//   gemm_done_i              engine finished the current tile
//   busy_o, done_o           job in progress / job-complete pulse
//   perf_cycles_o            busy-cycle counter
//
// Optional feature macro: SNAX_GEMM_SEQ_PERF_EN
//   defined   -> perf_cycles_o counts busy cycles of the most recent job
//                (saturating at 0xFFFFFFFF, cleared when a job is accepted)
//   undefined -> perf_cycles_o is tied to zero and no counter flops exist
// -----------------------------------------------------------------------------
module snax_gemm_tile_sequencer #(
  parameter int unsigned AddrWidth  = 17,
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned TileBytesA = 64,
  parameter int unsigned TileBytesB = 64,
  parameter int unsigned TileBytesC = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [AddrWidth-1:0] cfg_base_a_i,
  input  logic [AddrWidth-1:0] cfg_base_b_i,
  input  logic [AddrWidth-1:0] cfg_base_c_i,
  input  logic [CntWidth-1:0]  cfg_m_i,
  input  logic [CntWidth-1:0]  cfg_n_i,
  input  logic [CntWidth-1:0]  cfg_k_i,
  input  logic                 abort_i,
  output logic                 gemm_start_o,
  input  logic                 gemm_ready_i,
  output logic [AddrWidth-1:0] gemm_addr_a_o,
  output logic [AddrWidth-1:0] gemm_addr_b_o,
  output logic [AddrWidth-1:0] gemm_addr_c_o,
  output logic                 gemm_accumulate_o,
  input  logic                 gemm_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          perf_cycles_o
);

  localparam logic [AddrWidth-1:0] StepA = AddrWidth'(TileBytesA);
  localparam logic [AddrWidth-1:0] StepB = AddrWidth'(TileBytesB);
  localparam logic [AddrWidth-1:0] StepC = AddrWidth'(TileBytesC);
  localparam logic [CntWidth-1:0]  CntOne = CntWidth'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Loop counters and their terminal values (count - 1, latched at accept).
  logic [CntWidth-1:0] m_q, n_q, k_q;
  logic [CntWidth-1:0] m_last_q, n_last_q, k_last_q;

  // Address pointers. row_a_q remembers the A address of (m, n=any, k=0) so
  // A can rewind when n advances; base_b_q lets B rewind when m advances.
  logic [AddrWidth-1:0] ptr_a_q, ptr_b_q, ptr_c_q;
  logic [AddrWidth-1:0] row_a_q, base_b_q;

  logic accept, zero_size, handshake, tile_done, abort_act;
  logic k_wrap, n_wrap, m_wrap, last_tile;

  assign accept    = (state_q == IDLE) && cfg_valid_i;
  assign zero_size = (cfg_m_i == '0) || (cfg_n_i == '0) || (cfg_k_i == '0);
  assign handshake = (state_q == ISSUE) && gemm_ready_i;
  assign tile_done = (state_q == WAIT) && gemm_done_i;
  assign abort_act = abort_i && (state_q != IDLE);

  assign k_wrap    = (k_q == k_last_q);
  assign n_wrap    = (n_q == n_last_q);
  assign m_wrap    = (m_q == m_last_q);
  assign last_tile = k_wrap && n_wrap && m_wrap;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = zero_size ? DONE : ISSUE;
      ISSUE:   if (handshake) state_d = WAIT;
      WAIT:    if (tile_done) state_d = last_tile ? DONE : ISSUE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    // Abort wins over both the command handshake and a tile-done pulse.
    if (abort_act) state_d = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Loop counters and address pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      m_last_q <= '0;
      n_last_q <= '0;
      k_last_q <= '0;
      ptr_a_q  <= '0;
      ptr_b_q  <= '0;
      ptr_c_q  <= '0;
      row_a_q  <= '0;
      base_b_q <= '0;
    end else if (accept) begin
      // With a zero count these terminal values underflow, but no tile is
      // issued in that case so they are never compared.
      m_last_q <= cfg_m_i - CntOne;
      n_last_q <= cfg_n_i - CntOne;
      k_last_q <= cfg_k_i - CntOne;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      ptr_a_q  <= cfg_base_a_i;
      row_a_q  <= cfg_base_a_i;
      ptr_b_q  <= cfg_base_b_i;
      base_b_q <= cfg_base_b_i;
      ptr_c_q  <= cfg_base_c_i;
    end else if (abort_act || (tile_done && last_tile)) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else if (tile_done) begin
      if (!k_wrap) begin
        // Next k: A and B both step one tile, C stays on the same output tile.
        k_q     <= k_q + CntOne;
        ptr_a_q <= ptr_a_q + StepA;
        ptr_b_q <= ptr_b_q + StepB;
      end else if (!n_wrap) begin
        // Next n: A rewinds to the start of row m, B continues linearly
        // because (n+1)*K + 0 == n*K + (K-1) + 1.
        k_q     <= '0;
        n_q     <= n_q + CntOne;
        ptr_a_q <= row_a_q;
        ptr_b_q <= ptr_b_q + StepB;
        ptr_c_q <= ptr_c_q + StepC;
      end else begin
        // Next m: A continues linearly into row m+1, B rewinds to its base,
        // C continues linearly because (m+1)*N + 0 == m*N + (N-1) + 1.
        k_q     <= '0;
        n_q     <= '0;
        m_q     <= m_q + CntOne;
        ptr_a_q <= ptr_a_q + StepA;
        row_a_q <= ptr_a_q + StepA;
        ptr_b_q <= base_b_q;
        ptr_c_q <= ptr_c_q + StepC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cfg_ready_o       = (state_q == IDLE);
  assign gemm_start_o      = (state_q == ISSUE);
  assign busy_o            = (state_q == ISSUE) || (state_q == WAIT);
  // An abort arriving in DONE suppresses the completion pulse.
  assign done_o            = (state_q == DONE) && !abort_i;
  assign gemm_addr_a_o     = ptr_a_q;
  assign gemm_addr_b_o     = ptr_b_q;
  assign gemm_addr_c_o     = ptr_c_q;
  assign gemm_accumulate_o = (k_q != '0);

`ifdef SNAX_GEMM_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

endmodule
